// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter that grants one of NREQ requesters write access to a
// shared WIDTH-bit register bank, with req/gnt/ack handshake and bank clear.
module dff_bank_arbiter #(
    parameter  int NREQ  = 4,
    parameter  int WIDTH = 8,
    localparam int OW    = $clog2(NREQ)
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_clr,
    input  logic [NREQ-1:0]        i_req,
    input  logic [NREQ*WIDTH-1:0]  i_wdata,
    output logic [NREQ-1:0]        o_gnt,
    output logic                   o_ack,
    output logic [OW-1:0]          o_owner,
    output logic                   o_busy,
    output logic [WIDTH-1:0]       o_q,
    output logic [WIDTH-1:0]       o_qbar
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int unsigned NREQ_U   = NREQ;
    localparam int unsigned LAST_U   = NREQ - 1;
    localparam logic [OW:0]   NREQ_W   = NREQ_U[OW:0];
    localparam logic [OW-1:0] LAST_IDX = LAST_U[OW-1:0];

    state_t             r_state;
    logic [OW-1:0]      r_ptr;
    logic [OW-1:0]      r_owner;
    logic [NREQ-1:0]    r_gnt;
    logic               r_ack;
    logic [WIDTH-1:0]   r_q;

    logic [OW:0]        w_sum   [NREQ];
    logic [OW-1:0]      w_idx   [NREQ];
    logic [WIDTH-1:0]   w_wdata [NREQ];
    logic [NREQ-1:0]    w_hit;
    logic               w_found;
    logic [OW-1:0]      w_winner;
    logic [NREQ-1:0]    w_onehot;
    logic               w_owner_req;
    logic [OW-1:0]      w_next_ptr;

    // Candidate gi is the requester at distance gi from ptr, wrapping mod NREQ.
    // The sum never exceeds 2*(NREQ-1), which always fits in OW+1 bits.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_cand
            localparam int unsigned OFS = gi;
            assign w_sum[gi]   = {1'b0, r_ptr} + OFS[OW:0];
            assign w_idx[gi]   = (w_sum[gi] >= NREQ_W) ? (w_sum[gi][OW-1:0] - NREQ_W[OW-1:0])
                                                       : w_sum[gi][OW-1:0];
            assign w_hit[gi]   = i_req[w_idx[gi]];
            assign w_wdata[gi] = i_wdata[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Nearest hit to ptr wins: scan from the far end so the closest overwrites.
    always_comb begin
        w_found  = |w_hit;
        w_winner = w_idx[0];
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_hit[k]) begin
                w_winner = w_idx[k];
            end
        end
    end

    always_comb begin
        w_onehot           = '0;
        w_onehot[w_winner] = 1'b1;
    end

    assign w_owner_req = i_req[r_owner];
    assign w_next_ptr  = (r_owner == LAST_IDX) ? '0 : r_owner + 1'b1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
            r_gnt   <= '0;
            r_ack   <= 1'b0;
            r_q     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_clr) begin
                        r_q <= '0;
                    end else if (w_found) begin
                        r_gnt   <= w_onehot;
                        r_owner <= w_winner;
                        r_state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    r_gnt <= '0;
                    // A requester that dropped req before the write forfeits
                    // its turn without moving the pointer.
                    if (w_owner_req) begin
                        r_q     <= w_wdata[r_owner];
                        r_ack   <= 1'b1;
                        r_ptr   <= w_next_ptr;
                        r_state <= ST_DONE;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    r_ack   <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_gnt   <= '0;
                    r_ack   <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_gnt   = r_gnt;
    assign o_ack   = r_ack;
    assign o_owner = r_owner;
    assign o_busy  = (r_state != ST_IDLE);
    assign o_q     = r_q;
    assign o_qbar  = ~r_q;

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Self-checking bench for dff_bank_arbiter: scenario tasks with inline checks
// plus a scoreboard of expected (owner, data) writes popped on every ack.
module tb_dff_bank_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic        ack;
    logic [1:0]  owner;
    logic        busy;
    logic [7:0]  q;
    logic [7:0]  qbar;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int m_ptr    = 0;

    typedef struct packed {
        logic [1:0] owner;
        logic [7:0] data;
    } exp_t;

    exp_t sb_q[$];

    dff_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_clr   (clr),
        .i_req   (req),
        .i_wdata (wdata),
        .o_gnt   (gnt),
        .o_ack   (ack),
        .o_owner (owner),
        .o_busy  (busy),
        .o_q     (q),
        .o_qbar  (qbar)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every ack must match the oldest expected write.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && ack === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_ack: got owner=%0d q=%h, expected no ack", owner, q);
            end else begin
                e = sb_q.pop_front();
                if (owner !== e.owner || q !== e.data) begin
                    failures++;
                    $display("FAIL sb_write: got owner=%0d q=%h, expected owner=%0d q=%h",
                             owner, q, e.owner, e.data);
                end else begin
                    $display("write owner=%0d data=%h", owner, q);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int idx, input logic [7:0] v);
        wdata[idx*8 +: 8] = v;
    endtask

    function automatic int rr_pick(input logic [3:0] r, input int p);
        int idx;
        for (int k = 0; k < 4; k++) begin
            idx = (p + k) % 4;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        clr   = 1'b0;
        req   = 4'b1111;
        wdata = '0;
        repeat (3) tick();
        checks++;
        if ({gnt, ack, busy, owner} !== 8'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got gnt=%b ack=%b busy=%b owner=%0d, expected all zero", gnt, ack, busy, owner);
        end
        checks++;
        if (q !== 8'h00 || qbar !== 8'hFF) begin
            failures++;
            $display("FAIL reset_q: got q=%h qbar=%h, expected 00/ff", q, qbar);
        end
        req   = 4'b0000;
        rst_n = 1'b1;
        m_ptr = 0;
        req   = 4'b0010;
        tick();
        checks++;
        if (gnt !== 4'b0010 || busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_pre_gnt: got gnt=%b busy=%b, expected 0010/1", gnt, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({gnt, ack, busy, owner} !== 8'b0 || q !== 8'h00 || qbar !== 8'hFF) begin
            failures++;
            $display("FAIL reset_mid_grant: got gnt=%b ack=%b busy=%b owner=%0d q=%h qbar=%h, expected zeros q=00 qbar=ff",
                     gnt, ack, busy, owner, q, qbar);
        end
        tick();
        rst_n = 1'b1;
        req   = 4'b0100;
        tick();
        checks++;
        if (gnt !== 4'b0100) begin
            failures++;
            $display("FAIL reset_release_gnt: got %b expected 0100", gnt);
        end
        req = 4'b0000;
        tick();
        checks++;
        if (busy !== 1'b0 || ack !== 1'b0) begin
            failures++;
            $display("FAIL reset_withdraw: got busy=%b ack=%b expected 0/0", busy, ack);
        end
        $display("test_reset done");
    endtask

    task automatic test_single_write();
        req = 4'b0100;
        set_data(2, 8'hA5);
        sb_q.push_back('{owner: 2'd2, data: 8'hA5});
        tick();
        checks++;
        if (gnt !== 4'b0100 || owner !== 2'd2 || ack !== 1'b0 || q !== 8'h00) begin
            failures++;
            $display("FAIL single_e0: got gnt=%b owner=%0d ack=%b q=%h, expected 0100/2/0/00", gnt, owner, ack, q);
        end
        tick();
        checks++;
        if (ack !== 1'b1 || q !== 8'hA5 || qbar !== 8'h5A || owner !== 2'd2 || gnt !== 4'b0000) begin
            failures++;
            $display("FAIL single_e1: got ack=%b q=%h qbar=%h owner=%0d gnt=%b, expected 1/a5/5a/2/0000",
                     ack, q, qbar, owner, gnt);
        end
        req = 4'b0000;
        tick();
        checks++;
        if (ack !== 1'b0 || busy !== 1'b0 || q !== 8'hA5) begin
            failures++;
            $display("FAIL single_e2: got ack=%b busy=%b q=%h, expected 0/0/a5", ack, busy, q);
        end
        m_ptr = 3;
        $display("test_single_write done");
    endtask

    task automatic test_round_robin();
        int order[5] = '{0, 1, 2, 3, 0};
        int last_ack;
        int w;
        logic [3:0] eg;
        logic [7:0] ed;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (q !== 8'h00 || qbar !== 8'hFF || owner !== 2'd0) begin
            failures++;
            $display("FAIL rr_reset: got q=%h qbar=%h owner=%0d, expected 00/ff/0", q, qbar, owner);
        end
        tick();
        rst_n    = 1'b1;
        m_ptr    = 0;
        wdata    = 32'h44332211;
        req      = 4'b1111;
        last_ack = -1;
        for (int i = 0; i < 5; i++) begin
            w = order[i];
            if (i == 4) set_data(0, 8'h5A);
            ed = wdata[w*8 +: 8];
            eg = 4'b0001 << w;
            sb_q.push_back('{owner: w[1:0], data: ed});
            tick();
            checks++;
            if (gnt !== eg || owner !== w[1:0]) begin
                failures++;
                $display("FAIL rr_gnt[%0d]: got gnt=%b owner=%0d, expected %b/%0d", i, gnt, owner, eg, w);
            end
            tick();
            checks++;
            if (ack !== 1'b1 || q !== ed) begin
                failures++;
                $display("FAIL rr_write[%0d]: got ack=%b q=%h, expected 1/%h", i, ack, q, ed);
            end
            if (last_ack >= 0) begin
                checks++;
                if (cyc - last_ack !== 3) begin
                    failures++;
                    $display("FAIL rr_spacing[%0d]: got %0d cycles, expected 3", i, cyc - last_ack);
                end
            end
            last_ack = cyc;
            if (i == 4) req = 4'b0000;
            tick();
            checks++;
            if (ack !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL rr_done[%0d]: got ack=%b busy=%b, expected 0/0", i, ack, busy);
            end
            m_ptr = (w + 1) % 4;
        end
        $display("test_round_robin done");
    endtask

    task automatic test_fairness();
        logic [3:0] masks[3] = '{4'b0010, 4'b0011, 4'b0010};
        int         expw[3]  = '{1, 0, 1};
        logic [3:0] eg;
        logic [7:0] ed;
        for (int i = 0; i < 3; i++) begin
            ed = 8'hC0 + 8'(i);
            set_data(expw[i], ed);
            eg = 4'b0001 << expw[i];
            sb_q.push_back('{owner: expw[i][1:0], data: ed});
            req = masks[i];
            tick();
            checks++;
            if (gnt !== eg) begin
                failures++;
                $display("FAIL fair_gnt[%0d]: got %b expected %b", i, gnt, eg);
            end
            tick();
            checks++;
            if (ack !== 1'b1 || q !== ed) begin
                failures++;
                $display("FAIL fair_write[%0d]: got ack=%b q=%h, expected 1/%h", i, ack, q, ed);
            end
            req = 4'b0000;
            tick();
            m_ptr = (expw[i] + 1) % 4;
        end
        $display("test_fairness done");
    endtask

    task automatic test_withdrawal();
        int w;
        logic [3:0] eg;
        logic [7:0] q_before;
        q_before = q;
        req = 4'b1000;
        tick();
        checks++;
        if (gnt !== 4'b1000 || owner !== 2'd3) begin
            failures++;
            $display("FAIL wd_gnt: got gnt=%b owner=%0d expected 1000/3", gnt, owner);
        end
        req = 4'b0000;
        tick();
        checks++;
        if (gnt !== 4'b0000 || ack !== 1'b0 || busy !== 1'b0 || q !== q_before) begin
            failures++;
            $display("FAIL wd_abort: got gnt=%b ack=%b busy=%b q=%h, expected 0000/0/0/%h",
                     gnt, ack, busy, q, q_before);
        end
        tick();
        checks++;
        if (ack !== 1'b0) begin
            failures++;
            $display("FAIL wd_no_ack: got ack=%b expected 0", ack);
        end
        w  = rr_pick(4'b1001, m_ptr);
        eg = 4'b0001 << w;
        set_data(w, 8'h96);
        sb_q.push_back('{owner: w[1:0], data: 8'h96});
        req = 4'b1001;
        tick();
        checks++;
        if (gnt !== eg) begin
            failures++;
            $display("FAIL wd_regrant: got %b expected %b", gnt, eg);
        end
        tick();
        req = 4'b0000;
        tick();
        m_ptr = (w + 1) % 4;
        $display("test_withdrawal done");
    endtask

    task automatic test_clear();
        int w;
        w = rr_pick(4'b0010, m_ptr);
        set_data(w, 8'h3C);
        sb_q.push_back('{owner: w[1:0], data: 8'h3C});
        req = 4'b0010;
        tick();
        tick();
        req = 4'b0000;
        tick();
        m_ptr = (w + 1) % 4;
        checks++;
        if (q !== 8'h3C) begin
            failures++;
            $display("FAIL clr_setup: got q=%h expected 3c", q);
        end
        clr = 1'b1;
        req = 4'b0001;
        tick();
        checks++;
        if (q !== 8'h00 || qbar !== 8'hFF || gnt !== 4'b0000 || busy !== 1'b0) begin
            failures++;
            $display("FAIL clr_priority: got q=%h qbar=%h gnt=%b busy=%b, expected 00/ff/0000/0", q, qbar, gnt, busy);
        end
        clr = 1'b0;
        set_data(0, 8'hE7);
        sb_q.push_back('{owner: 2'd0, data: 8'hE7});
        tick();
        checks++;
        if (gnt !== 4'b0001) begin
            failures++;
            $display("FAIL clr_then_gnt: got %b expected 0001", gnt);
        end
        clr = 1'b1;
        tick();
        checks++;
        if (ack !== 1'b1 || q !== 8'hE7) begin
            failures++;
            $display("FAIL clr_in_grant: got ack=%b q=%h, expected 1/e7", ack, q);
        end
        req = 4'b0000;
        tick();
        checks++;
        if (q !== 8'hE7 || busy !== 1'b0) begin
            failures++;
            $display("FAIL clr_in_done: got q=%h busy=%b, expected e7/0", q, busy);
        end
        clr = 1'b0;
        tick();
        m_ptr = 1;
        $display("test_clear done");
    endtask

    task automatic test_reset_done();
        int w;
        w = rr_pick(4'b0100, m_ptr);
        set_data(w, 8'h77);
        sb_q.push_back('{owner: w[1:0], data: 8'h77});
        req = 4'b0100;
        tick();
        tick();
        #6 rst_n = 1'b0;
        #1;
        checks++;
        if ({gnt, ack, busy, owner} !== 8'b0 || q !== 8'h00 || qbar !== 8'hFF) begin
            failures++;
            $display("FAIL reset_mid_done: got gnt=%b ack=%b busy=%b owner=%0d q=%h qbar=%h, expected zeros q=00 qbar=ff",
                     gnt, ack, busy, owner, q, qbar);
        end
        req = 4'b0000;
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || q !== 8'h00 || ack !== 1'b0) begin
            failures++;
            $display("FAIL reset_done_after: got busy=%b q=%h ack=%b, expected 0/00/0", busy, q, ack);
        end
        m_ptr = 0;
        $display("test_reset_done done");
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_fairness();
        test_withdrawal();
        test_clear();
        test_reset_done();
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover: got %0d pending writes, expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dff_bank_arbiter.md
# dff_bank_arbiter

Round-robin arbiter and write sequencer for a shared WIDTH-bit D flip-flop register bank. NREQ requesters compete for write access through a req/gnt/ack handshake. The block grants one requester at a time and loads that requester's data into the bank. It presents the bank contents as q and its complement qbar to downstream logic, and sits between the requesting datapath units and any consumer of the stored value.

## Interface
- NREQ, default 4: number of requesters; legal range 2..16.
- WIDTH, default 8: register bank width in bits.
- OW, default $clog2(NREQ): owner index width; derived, not overridden.

Ports:
- clk, input, 1: single clock; all state updates on its rising edge.
- rst, input, 1: reset, asynchronous, active-low.
- clr, input, 1: synchronous clear request for the bank; sampled only in IDLE.
- req, input, NREQ: per-requester write request; must be held until gnt is seen.
- wdata, input, NREQ*WIDTH: write data; requester i drives bits [i*WIDTH +: WIDTH].
- gnt, output, NREQ: one-hot grant, registered.
- ack, output, 1: one-cycle pulse meaning the bank was written for the current owner.
- owner, output, OW: index of the current or most recent grantee.
- busy, output, 1: high whenever the state is not IDLE.
- q, output, WIDTH: register bank contents.
- qbar, output, WIDTH: combinational ~q at all times.

## Operation
States: IDLE, GRANT, DONE. The encoding is free.

IDLE:
- If clr=1, then q<=0 at the next edge and the state stays IDLE. No grant is issued, req is ignored that cycle, and ptr is unchanged.
- Otherwise, if any req bit is high, pick the winner. The search starts at index ptr and increases mod NREQ; the first set bit wins.
- At the next edge: gnt<=onehot(winner), owner<=winner, state->GRANT.
- With no req and no clr, the state holds IDLE and all outputs hold.

GRANT:
- gnt is high for exactly this cycle.
- If req[owner]=1 at the closing edge:
  - q<=wdata[owner] as sampled at that edge.
  - ack<=1, gnt<=0.
  - ptr<=(owner+1) mod NREQ.
  - state->DONE.
- If req[owner]=0 at the closing edge (requester withdrew):
  - gnt<=0; no write; ack stays 0.
  - ptr unchanged.
  - state->IDLE.
- Changes on other req bits during GRANT are ignored.

DONE:
- ack is high for this cycle only, and q already holds the new value.
- At the next edge: ack<=0, state->IDLE.
- The requester drops req on seeing ack. A req bit still high in the following IDLE cycle counts as a new request.

Round-robin rule:
- ptr advances only on a completed write.
- ptr is never exposed as a port.
- A requester that has just been served has the lowest priority in the next arbitration.

Reset (rst=0, asserted asynchronously, at any time including mid-GRANT or mid-DONE):
- State returns to IDLE.
- q=0, so qbar=all ones.
- gnt=0, ack=0, busy=0, owner=0, ptr=0.
- An in-flight write is discarded.
- Release is synchronous to clk. The first arbitration happens at the first rising edge with rst=1.

## Timing
- Request to grant: req high before edge E0 (state IDLE) gives gnt visible after E0.
- Write: q, qbar and ack are visible after E1. Latency from req to q update is 2 edges.
- ack deasserts after E2, when the state returns to IDLE. The next arbitration samples req at E3 at the earliest.
- Throughput is at most one write per 3 cycles.
- clr takes effect 1 edge after it is sampled in IDLE.
- clr arriving in GRANT or DONE is ignored; the source must hold it until busy=0.
- busy tracks the state registers. There is no combinational path from req to gnt.
- The only combinational outputs are qbar and busy.

## Test plan
- Reset: drive rst=0 mid-GRANT with gnt=4'b0010 → immediately gnt=0, ack=0, q=8'h00, qbar=8'hFF, busy=0, owner=0. After release, req=4'b0100 → gnt=4'b0100 one edge later.
- Single write: after reset, req[2]=1, wdata[2]=8'hA5 → gnt=4'b0100 after E0. After E1: q=8'hA5, qbar=8'h5A, ack=1, owner=2. After E2: ack=0, busy=0.
- Round-robin: req=4'b1111 held and re-raised after each ack → grant order 0,1,2,3,0. Each ack is one cycle and the writes are spaced 3 cycles apart.
- Fairness after service: requester 1 served, then req=4'b0011 → the next grant goes to 0? No: ptr=2, so the search order is 2,3,0,1 and the grant goes to 0. Then req=4'b0010 alone → grant to 1.
- Withdrawal: req[3] rises and gnt=4'b1000 is issued. req[3] drops during GRANT → no ack, q unchanged, back in IDLE. Next req=4'b1001 → grant to 3, because ptr did not advance.
- Clear priority: q=8'h3C in IDLE, with clr=1 and req=4'b0001 in the same cycle → q=8'h00 and qbar=8'hFF after one edge, no gnt. With clr=0 the following cycle → gnt=4'b0001 issued.
